// File: rtl/game_pkg.sv
// Shared game constants and state encoding for the score keeper and the
// seven-segment status display stage that consumes its lifes/points outputs.
// Bonus-life support in score_keeper is selected by SCORE_KEEPER_BONUS_LIFE_EN.
package game_pkg;

    // Round state machine encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    // Output ranges shared with the display stage
    localparam int POINTS_W   = 10;
    localparam int LIFES_W    = 2;
    localparam int MAX_POINTS = 999;
    localparam int MAX_LIFES  = 3;

    // Hundreds digit of a score; a bonus life is granted when it changes
    function automatic logic [3:0] hundreds(input logic [POINTS_W-1:0] p);
        logic [POINTS_W-1:0] q;
        q = p / POINTS_W'(100);
        return q[3:0];
    endfunction

endpackage

// File: rtl/respawn_timer.sv
// Respawn delay counter: load sets RESPAWN_CYCLES-1, count decrements toward 0.
// done is high while the counter sits at zero; the owner uses done as the exit
// condition, which yields a dwell of exactly RESPAWN_CYCLES counting cycles.
module respawn_timer #(
    parameter int unsigned RESPAWN_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);

    // At least one bit so RESPAWN_CYCLES=1 still builds
    localparam int unsigned CW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(RESPAWN_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register, cleared by reset so a reset mid-delay leaves no residue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/score_keeper.sv
// Game score/lives tracker and round state machine (IDLE/PLAYING/RESPAWN/GAME_OVER).
// All outputs registered: an event sampled on one edge is visible right after it.
// Optional macro SCORE_KEEPER_BONUS_LIFE_EN adds a life on every 100-point crossing.
module score_keeper
    import game_pkg::*;
#(
    parameter int unsigned POINTS_PER_BRICK = 1,
    parameter int unsigned RESPAWN_CYCLES   = 50_000_000,
    parameter int unsigned START_LIFES      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_game,
    input  logic                brick_hit,
    input  logic                ball_lost,
    output logic [LIFES_W-1:0]  lifes,
    output logic [POINTS_W-1:0] points,
    output logic                ball_enable,
    output logic                game_over
);

    localparam logic [LIFES_W-1:0]  START_L = LIFES_W'(START_LIFES);
    localparam logic [POINTS_W-1:0] SAT_P   = POINTS_W'(MAX_POINTS);

    game_state_t         state_q, state_d;
    logic [LIFES_W-1:0]  lifes_q, lifes_d;
    logic [POINTS_W-1:0] points_q, points_d;
    logic                ball_enable_q;
    logic                game_over_q;

    logic                timer_load;
    logic                timer_count;
    logic                timer_done;

    logic [31:0]         points_sum;
    logic [POINTS_W-1:0] points_hit;
    logic                bonus;
    logic [LIFES_W:0]    lives_up;
    logic [LIFES_W:0]    lives_dn;
    logic [LIFES_W-1:0]  lifes_after;

    // Saturating score after this cycle's brick_hit; 32-bit sum so a large
    // POINTS_PER_BRICK cannot wrap before the clamp
    always_comb begin
        points_sum = 32'(points_q) + 32'(POINTS_PER_BRICK);
        points_hit = points_q;
        if (brick_hit) begin
            points_hit = (points_sum > 32'(MAX_POINTS)) ? SAT_P : points_sum[POINTS_W-1:0];
        end
    end

`ifdef SCORE_KEEPER_BONUS_LIFE_EN
    // A change of the hundreds digit means a multiple of 100 was crossed
    always_comb begin
        bonus = brick_hit && (hundreds(points_hit) != hundreds(points_q));
    end
`else
    // Lives only change on ball_lost and reload
    assign bonus = 1'b0;
`endif

    // Net life change for a PLAYING edge: bonus and loss merged into one
    // update, floored at 0 and capped at MAX_LIFES
    always_comb begin
        lives_up = {1'b0, lifes_q} + {{LIFES_W{1'b0}}, bonus};
        lives_dn = lives_up;
        if (ball_lost && (lives_up != '0)) begin
            lives_dn = lives_up - (LIFES_W+1)'(1);
        end
        lifes_after = (lives_dn > (LIFES_W+1)'(MAX_LIFES)) ? LIFES_W'(MAX_LIFES)
                                                          : lives_dn[LIFES_W-1:0];
    end

    // Round state machine next-state; new_game overrides every other event
    always_comb begin
        state_d    = state_q;
        lifes_d    = lifes_q;
        points_d   = points_q;
        timer_load = 1'b0;
        if (new_game) begin
            state_d  = PLAYING;
            lifes_d  = START_L;
            points_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                PLAYING: begin
                    // Score lands in the same edge as any loss-driven transition
                    points_d = points_hit;
                    lifes_d  = lifes_after;
                    if (ball_lost) begin
                        if (lifes_after == '0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d    = RESPAWN;
                            timer_load = 1'b1;
                        end
                    end
                end
                RESPAWN: begin
                    if (timer_done) begin
                        state_d = PLAYING;
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign timer_count = (state_q == RESPAWN);

    respawn_timer #(
        .RESPAWN_CYCLES (RESPAWN_CYCLES)
    ) u_respawn_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .count (timer_count),
        .done  (timer_done)
    );

    // State, score, lives and the state-decoded outputs, all registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lifes_q       <= START_L;
            points_q      <= '0;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lifes_q       <= lifes_d;
            points_q      <= points_d;
            ball_enable_q <= (state_d == PLAYING);
            game_over_q   <= (state_d == GAME_OVER);
        end
    end

    assign lifes       = lifes_q;
    assign points      = points_q;
    assign ball_enable = ball_enable_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a behavioural model feeding a scoreboard queue.
// Expected outputs are pushed when each stimulus cycle is driven, popped after the edge.
// Bonus-life expectations follow SCORE_KEEPER_BONUS_LIFE_EN when it is defined.
module tb_score_keeper;

    localparam int RC = 4;
    localparam int SL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_game = 1'b0;
    logic       brick_hit = 1'b0;
    logic       ball_lost = 1'b0;
    logic [1:0] lifes;
    logic [9:0] points;
    logic       ball_enable;
    logic       game_over;

    score_keeper #(
        .POINTS_PER_BRICK (1),
        .RESPAWN_CYCLES   (RC),
        .START_LIFES      (SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .brick_hit   (brick_hit),
        .ball_lost   (ball_lost),
        .lifes       (lifes),
        .points      (points),
        .ball_enable (ball_enable),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] l;
        logic [9:0] p;
        logic       be;
        logic       go;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Model: 0 idle, 1 playing, 2 respawn, 3 game over
    int m_st  = 0;
    int m_l   = SL;
    int m_p   = 0;
    int m_rem = 0;

    task automatic model_reset();
        m_st = 0; m_l = SL; m_p = 0; m_rem = 0;
    endtask

    task automatic model_step(input bit ng, input bit bh, input bit bl);
        int np;
        int bonus;
        if (ng) begin
            m_st = 1; m_l = SL; m_p = 0;
        end else if (m_st == 1) begin
            np = m_p;
            if (bh) np = (m_p + 1 > 999) ? 999 : m_p + 1;
            bonus = 0;
`ifdef SCORE_KEEPER_BONUS_LIFE_EN
            if ((np / 100) != (m_p / 100)) bonus = 1;
`endif
            m_p = np;
            m_l = m_l + bonus - (bl ? 1 : 0);
            if (m_l < 0) m_l = 0;
            if (m_l > 3) m_l = 3;
            if (bl) begin
                if (m_l == 0) m_st = 3;
                else begin m_st = 2; m_rem = RC; end
            end
        end else if (m_st == 2) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_st = 1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.l  = 2'(m_l);
        e.p  = 10'(m_p);
        e.be = (m_st == 1);
        e.go = (m_st == 3);
        sbq.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            assert (lifes === e.l) else begin
                errors++;
                $error("FAIL %s lifes: observed=%0d expected=%0d", tag, lifes, e.l);
            end
            checks++;
            assert (points === e.p) else begin
                errors++;
                $error("FAIL %s points: observed=%0d expected=%0d", tag, points, e.p);
            end
            checks++;
            assert (ball_enable === e.be) else begin
                errors++;
                $error("FAIL %s ball_enable: observed=%0b expected=%0b", tag, ball_enable, e.be);
            end
            checks++;
            assert (game_over === e.go) else begin
                errors++;
                $error("FAIL %s game_over: observed=%0b expected=%0b", tag, game_over, e.go);
            end
        end
    endtask

    // One clocked cycle: drive inputs, predict, then compare just after the edge
    task automatic step(input bit ng, input bit bh, input bit bl, input string tag);
        new_game  = ng;
        brick_hit = bh;
        ball_lost = bl;
        model_step(ng, bh, bl);
        push_exp();
        @(posedge clk);
        #1;
        new_game  = 1'b0;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        check_out(tag);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        model_reset();
        push_exp();
        check_out("reset_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_exp();
        check_out("reset_release");

        // IDLE ignores gameplay events
        step(0, 1, 0, "idle_hit");
        step(0, 0, 1, "idle_lost");

        // Start a game and score five back-to-back hits
        step(1, 0, 0, "new_game");
        repeat (5) step(0, 1, 0, "hit5");

        // Lose a ball: four respawn cycles with ball disabled, then playing
        step(0, 0, 1, "lost1");
        repeat (5) step(0, 0, 0, "respawn1");
        step(0, 0, 1, "lost2");
        repeat (4) step(0, 0, 0, "respawn2");
        step(0, 0, 1, "lost3_gameover");

        // Game over holds score and lives
        step(0, 1, 0, "go_hit");
        step(0, 0, 1, "go_lost");
        step(1, 0, 0, "restart");

        // Saturation at 999
        repeat (998) step(0, 1, 0, "preload");
        step(0, 1, 0, "sat_999");
        step(0, 1, 0, "sat_hold1");
        step(0, 1, 0, "sat_hold2");

        // new_game outranks simultaneous hit and loss
        step(1, 1, 1, "ng_priority");

        // Simultaneous hit and loss at points=10, lifes=2
        repeat (10) step(0, 1, 0, "to10");
        step(0, 0, 1, "lost_to2");
        repeat (4) step(0, 0, 0, "respawn3");
        step(0, 1, 1, "hit_and_lost");
        step(0, 0, 0, "respawn_mid");

        // Reset mid-respawn takes effect without a clock edge
        #3 rst = 1'b1;
        #1;
        model_reset();
        push_exp();
        check_out("rst_mid_respawn");
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 0, "idle_after_rst");

        // new_game during respawn re-enters playing immediately
        step(1, 0, 0, "new_game2");
        step(0, 0, 1, "lost_in_game2");
        step(1, 0, 0, "ng_in_respawn");

        // Hundreds crossings (lives grow only with the bonus feature)
        repeat (99) step(0, 1, 0, "to99");
        step(0, 0, 1, "lost_at99");
        repeat (4) step(0, 0, 0, "respawn4");
        step(0, 1, 0, "cross100");
        repeat (99) step(0, 1, 0, "to199");
        step(0, 1, 0, "cross200");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
